// File: rtl/md_pkg.sv
// md_pkg: shared opcodes, cycle defaults and FSM encoding for the md scheduler.
// Optional MADD/MADDU support is enabled by defining MD_MADD_EN.
package md_pkg;

   localparam logic [3:0] OP_NOP   = 4'd0;
   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MTHI  = 4'd5;
   localparam logic [3:0] OP_MTLO  = 4'd6;
   localparam logic [3:0] OP_MADD  = 4'd7;
   localparam logic [3:0] OP_MADDU = 4'd8;

   localparam int MD_MULT_CYCLES = 5;
   localparam int MD_DIV_CYCLES  = 10;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } md_state_e;

   // Ops that occupy the unit for several cycles.
   function automatic logic op_is_long(input logic [3:0] op);
`ifdef MD_MADD_EN
      return (op == OP_MULT) || (op == OP_MULTU) ||
             (op == OP_DIV)  || (op == OP_DIVU)  ||
             (op == OP_MADD) || (op == OP_MADDU);
`else
      return (op == OP_MULT) || (op == OP_MULTU) ||
             (op == OP_DIV)  || (op == OP_DIVU);
`endif
   endfunction

   function automatic logic op_is_div(input logic [3:0] op);
      return (op == OP_DIV) || (op == OP_DIVU);
   endfunction

   // Any op that is not treated as a NOP.
   function automatic logic op_is_md(input logic [3:0] op);
      return op_is_long(op) || (op == OP_MTHI) || (op == OP_MTLO);
   endfunction

endpackage

// File: rtl/md_arith.sv
// md_arith: combinational mult/div/madd datapath producing the HI/LO result.
// Ports: op, a, b, hi, lo in; res_hi, res_lo, div0 out. MD_MADD_EN adds MADD/MADDU.
module md_arith
   import md_pkg::*;
(
   input  logic [3:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [31:0] hi,
   input  logic [31:0] lo,
   output logic [31:0] res_hi,
   output logic [31:0] res_lo,
   output logic        div0
);

   logic [63:0] prod_s;
   logic [63:0] prod_u;
   logic [31:0] b_nz;
   logic [31:0] abs_a;
   logic [31:0] abs_b;
   logic [31:0] sq_mag;
   logic [31:0] sr_mag;
   logic [31:0] sq;
   logic [31:0] sr;
   logic [31:0] uq;
   logic [31:0] ur;

   assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
   assign prod_u = {32'd0, a} * {32'd0, b};

   // Never divide by zero; the result is discarded via div0 anyway.
   assign b_nz = (b == 32'd0) ? 32'd1 : b;

   // Signed divide on magnitudes avoids the MIN/-1 overflow case:
   // 0x80000000 / -1 yields 0x80000000 with zero remainder.
   assign abs_a  = a[31] ? -a : a;
   assign abs_b  = b_nz[31] ? -b_nz : b_nz;
   assign sq_mag = abs_a / abs_b;
   assign sr_mag = abs_a % abs_b;
   assign sq     = (a[31] ^ b[31]) ? -sq_mag : sq_mag;
   assign sr     = a[31] ? -sr_mag : sr_mag;

   assign uq = a / b_nz;
   assign ur = a % b_nz;

   always_comb begin
      res_hi = hi;
      res_lo = lo;
      div0   = 1'b0;
      case (op)
         OP_MULT:  {res_hi, res_lo} = prod_s;
         OP_MULTU: {res_hi, res_lo} = prod_u;
         OP_DIV: begin
            if (b == 32'd0) begin
               div0 = 1'b1;
            end else begin
               res_hi = sr;
               res_lo = sq;
            end
         end
         OP_DIVU: begin
            if (b == 32'd0) begin
               div0 = 1'b1;
            end else begin
               res_hi = ur;
               res_lo = uq;
            end
         end
`ifdef MD_MADD_EN
         OP_MADD:  {res_hi, res_lo} = {hi, lo} + prod_s;
         OP_MADDU: {res_hi, res_lo} = {hi, lo} + prod_u;
`endif
         default: ;
      endcase
   end

endmodule

// File: rtl/md_sched.sv
// md_sched: multi-cycle mult/div scheduler holding HI/LO and raising stall.
// Ports: clk, rst, start, op, a, b, md_use_d in; hi, lo, busy, stall out. Macro MD_MADD_EN.
module md_sched
   import md_pkg::*;
#(
   parameter int MULT_CYCLES = MD_MULT_CYCLES,
   parameter int DIV_CYCLES  = MD_DIV_CYCLES
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [3:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        md_use_d,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic        busy,
   output logic        stall
);

   localparam int CMAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW   = $clog2(CMAX + 1);

   md_state_e   state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [31:0] pend_hi, pend_hi_n;
   logic [31:0] pend_lo, pend_lo_n;
   logic        pend_wr, pend_wr_n;
   logic [31:0] hi_n, lo_n;
   logic [31:0] res_hi, res_lo;
   logic        div0;

   // HI/LO cannot change while busy, so the accumulate value seen
   // here at issue equals the value at commit.
   md_arith u_arith (
      .op     (op),
      .a      (a),
      .b      (b),
      .hi     (hi),
      .lo     (lo),
      .res_hi (res_hi),
      .res_lo (res_lo),
      .div0   (div0)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_IDLE;
         cnt     <= '0;
         pend_hi <= '0;
         pend_lo <= '0;
         pend_wr <= 1'b0;
         hi      <= '0;
         lo      <= '0;
      end else begin
         state   <= state_n;
         cnt     <= cnt_n;
         pend_hi <= pend_hi_n;
         pend_lo <= pend_lo_n;
         pend_wr <= pend_wr_n;
         hi      <= hi_n;
         lo      <= lo_n;
      end
   end

   always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      pend_hi_n = pend_hi;
      pend_lo_n = pend_lo;
      pend_wr_n = pend_wr;
      hi_n      = hi;
      lo_n      = lo;
      case (state)
         ST_IDLE: begin
            if (start) begin
               if (op_is_long(op)) begin
                  pend_hi_n = res_hi;
                  pend_lo_n = res_lo;
                  pend_wr_n = ~div0;
                  cnt_n     = op_is_div(op) ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                  state_n   = ST_RUN;
               end else if (op == OP_MTHI) begin
                  hi_n = a;
               end else if (op == OP_MTLO) begin
                  lo_n = a;
               end
            end
         end
         ST_RUN: begin
            cnt_n = cnt - 1'b1;
            if (cnt == CW'(1)) begin
               state_n = ST_IDLE;
               if (pend_wr) begin
                  hi_n = pend_hi;
                  lo_n = pend_lo;
               end
            end
         end
         default: state_n = ST_IDLE;
      endcase
   end

   assign busy  = (state == ST_RUN);
   assign stall = md_use_d & (busy | (start & op_is_md(op)));

endmodule
